// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small in-order instruction queue and redirect/flush handling.
// Optional macro IFETCH_QUEUE_BYPASS_EN presents a response to an empty queue in its ack cycle.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        inst_mem_q [DEPTH];

  logic empty, issue, ack_ok, bypass_hit, push, pop, pop_q;

  assign empty  = (count_q == '0);
  assign issue  = !redirect_i && (count_q < FULL);
  assign ack_ok = (state_q == WAIT) && imem_ack_i && !redirect_i;

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && ack_ok;
`else
  assign bypass_hit = 1'b0;
`endif

  assign valid_o = !empty || bypass_hit;
  assign pop     = valid_o && ready_i;
  assign pop_q   = pop && !empty;
  // A bypassed response consumed this cycle never enters the queue.
  assign push    = ack_ok && !(bypass_hit && ready_i);

  always_comb begin
    inst_o = 32'h0;
    pc_o   = 32'h0;
    if (!empty) begin
      inst_o = inst_mem_q[rd_ptr_q];
      pc_o   = pc_mem_q[rd_ptr_q];
    end else if (bypass_hit) begin
      inst_o = imem_data_i;
      pc_o   = fetch_pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT: begin
        if (imem_ack_i)      state_d = IDLE;
        else if (redirect_i) state_d = DROP;
      end
      DROP:    if (imem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q == WAIT);
    imem_addr_o = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_i) begin
      // Flush wins over any same-cycle push or pop.
      fetch_pc_d = redirect_addr_i & 32'hFFFF_FFFC;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (ack_ok) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop_q)  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      case ({push, pop_q})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a bench-side memory responder plus directed scenarios,
// with a monitor that compares every accepted instruction against the expected queue.
module tb_ifetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  ifetch_queue dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Memory responder state
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_budget;
  int          ack_cnt;
  logic [31:0] slow_addr;
  int          slow_lat;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 32'h2008_0005;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_data(pc);
    sb.push_back(e);
  endtask

  // One cycle: at the falling edge the memory model updates its response, then inputs settle.
  task automatic tick();
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_data(mem_addr);
        mem_busy    = 1'b0;
        ack_cnt++;
      end
    end else if (imem_req_o && mem_budget > 0) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_budget--;
      mem_cnt  = (imem_addr_o == slow_addr) ? slow_lat : 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i           = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    ready_i         = 1'b0;
    imem_ack_i      = 1'b0;
    mem_busy        = 1'b0;
    mem_budget      = 0;
    ack_cnt         = 0;
    slow_addr       = 32'hFFFF_FFF0;
    slow_lat        = 1;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'((sb.size() == 0) && !valid_o), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] addr, input string name);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == addr) && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(imem_req_o && imem_addr_o == addr), 32'd1);
  endtask

  // Monitor: compares every accepted head entry, sampled just before the rising edge.
  always @(negedge clk_i) begin
    exp_t e;
    #4;
    if (rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got pc 0x%08h inst 0x%08h, required no entry", pc_o, inst_o);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_inst", inst_o, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, v, n;
    rst_i           = 1'b1;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    ready_i         = 1'b0;
    imem_ack_i      = 1'b0;
    imem_data_i     = 32'h0;
    mem_busy        = 1'b0;
    mem_budget      = 0;
    slow_addr       = 32'hFFFF_FFF0;
    slow_lat        = 1;
    #2;

    // Reset state
    rst_i = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);

    // Streaming fetch with single-cycle memory and ready held high
    do_reset();
    ready_i    = 1'b1;
    mem_budget = 4;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    r = -1;
    v = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (r < 0 && imem_req_o) begin
        r = c;
        check("t1_first_addr", imem_addr_o, 32'h0);
      end
      if (v < 0 && valid_o) v = c;
    end
    check("t1_first_req_cycle", 32'(r), 32'd0);
`ifdef IFETCH_QUEUE_BYPASS_EN
    check("t1_req_to_valid", 32'(v - r), 32'd1);
`else
    check("t1_req_to_valid", 32'(v - r), 32'd2);
`endif
    wait_drained("t1_drain");
    check("t1_stall_req", 32'(imem_req_o), 32'd1);
    check("t1_stall_addr", imem_addr_o, 32'h10);

    // Back-pressure fills the queue, then release drains it in order
    do_reset();
    mem_budget = 10;
    for (int c = 0; c < 24; c++) tick();
    check("t2_push_count", 32'(ack_cnt), 32'd4);
    check("t2_full_no_req", 32'(imem_req_o), 32'd0);
    check("t2_full_valid", 32'(valid_o), 32'd1);
    check("t2_head_pc", pc_o, 32'h0);
    check("t2_head_inst", inst_o, mem_data(32'h0));
    mem_budget = 2;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    expect_pc(32'hC); expect_pc(32'h10); expect_pc(32'h14);
    ready_i = 1'b1;
    wait_drained("t2_drain");
    check("t2_stall_addr", imem_addr_o, 32'h18);

    // Redirect while the request to 0x8 is outstanding: its late response is dropped
    do_reset();
    mem_budget = 4;
    slow_addr  = 32'h8;
    slow_lat   = 3;
    wait_req(32'h8, "t3_req8");
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h43;
    tick();
    redirect_i = 1'b0;
    check("t3_flush_empty", 32'(valid_o), 32'd0);
    check("t3_drop_no_req", 32'(imem_req_o), 32'd0);
    n = 0;
    while (!imem_req_o && n < 10) begin
      tick();
      n++;
    end
    check("t3_new_addr", imem_addr_o, 32'h40);
    check("t3_old_ack_seen", 32'(ack_cnt), 32'd3);
    check("t3_dropped_not_queued", 32'(valid_o), 32'd0);
    expect_pc(32'h40);
    ready_i = 1'b1;
    wait_drained("t3_drain");
    check("t3_stall_addr", imem_addr_o, 32'h44);

    // Redirect coincident with the ack: response dropped, no DROP state
    do_reset();
    ready_i    = 1'b1;
    mem_budget = 2;
    n = 0;
    while (!imem_ack_i && n < 10) begin
      tick();
      n++;
    end
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h80;
    tick();
    redirect_i = 1'b0;
    check("t4_idle_no_req", 32'(imem_req_o), 32'd0);
    tick();
    check("t4_req_after", 32'(imem_req_o), 32'd1);
    check("t4_addr_after", imem_addr_o, 32'h80);
    expect_pc(32'h80);
    wait_drained("t4_drain");
    check("t4_stall_addr", imem_addr_o, 32'h84);

    // Fetch address wraps past the top of the address space
    do_reset();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFC;
    ready_i         = 1'b1;
    mem_budget      = 1;
    expect_pc(32'hFFFF_FFFC);
    tick();
    redirect_i = 1'b0;
    check("t5_idle_redirect_no_req", 32'(imem_req_o), 32'd0);
    wait_drained("t5_drain");
    check("t5_wrap_req", 32'(imem_req_o), 32'd1);
    check("t5_wrap_addr", imem_addr_o, 32'h0);

    // Reset mid-request; the late ack lands in IDLE and must be ignored
    do_reset();
    ready_i    = 1'b1;
    mem_budget = 2;
    slow_addr  = 32'h0;
    slow_lat   = 3;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("t7_rst_req", 32'(imem_req_o), 32'd0);
    tick();
    tick();
    rst_i = 1'b1;
    check("t7_late_ack_present", 32'(imem_ack_i), 32'd1);
    tick();
    check("t7_late_ack_ignored", 32'(valid_o), 32'd0);
    check("t7_reissue_addr", imem_addr_o, 32'h0);
    expect_pc(32'h0);
    wait_drained("t7_drain");
    check("t7_stall_addr", imem_addr_o, 32'h4);

`ifdef IFETCH_QUEUE_BYPASS_EN
    // Bypass: response to an empty queue is visible in its ack cycle
    do_reset();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h10;
    ready_i         = 1'b1;
    mem_budget      = 1;
    expect_pc(32'h10);
    tick();
    redirect_i = 1'b0;
    n = 0;
    while (!imem_ack_i && n < 10) begin
      tick();
      n++;
    end
    check("t8_byp_valid", 32'(valid_o), 32'd1);
    check("t8_byp_inst", inst_o, 32'h2008_0005);
    check("t8_byp_pc", pc_o, 32'h10);
    wait_drained("t8_drain");
`endif

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_req_o, output, 1 bit: instruction memory read request.
REQ-006 The block SHALL have port imem_addr_o, output, 32 bits: fetch address, word aligned.
REQ-007 The block SHALL have port imem_ack_i, input, 1 bit: memory response valid, one cycle per request.
REQ-008 The block SHALL have port imem_data_i, input, 32 bits: instruction word, valid when imem_ack_i=1.
REQ-009 The block SHALL have port redirect_i, input, 1 bit: branch/jump taken by the downstream stage.
REQ-010 The block SHALL have port redirect_addr_i, input, 32 bits: new PC on redirect.
REQ-011 The block SHALL have port valid_o, output, 1 bit: inst_o/pc_o hold a valid instruction.
REQ-012 The block SHALL have port ready_i, input, 1 bit: decode stage accepts the head entry.
REQ-013 The block SHALL have port inst_o, output, 32 bits: head instruction word.
REQ-014 The block SHALL have port pc_o, output, 32 bits: address of inst_o.

Function
REQ-015 The block SHALL run FSM states IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding response to be discarded).
REQ-016 In IDLE, when count + 0 < DEPTH and redirect_i=0, the block SHALL assert imem_req_o with imem_addr_o=fetch_pc and move to WAIT.
REQ-017 In WAIT, imem_req_o and imem_addr_o SHALL stay stable until imem_ack_i=1; at most one request SHALL be outstanding.
REQ-018 On imem_ack_i in WAIT without redirect_i, the block SHALL push {fetch_pc, imem_data_i}, set fetch_pc = fetch_pc + 4 (mod 2^32 wrap), and return to IDLE.
REQ-019 Issue SHALL require count + outstanding < DEPTH so a push never overflows; push and pop in the same cycle SHALL be allowed at any occupancy.
REQ-020 A pop SHALL occur when valid_o=1 and ready_i=1; valid_o SHALL equal (count != 0).
REQ-021 When empty, inst_o and pc_o SHALL be 0.
REQ-022 On redirect_i=1, the block SHALL flush all entries (count=0), load fetch_pc=redirect_addr_i, and, if a request is outstanding and imem_ack_i=0, enter DROP.
REQ-023 Redirect coincident with imem_ack_i SHALL discard that response and go to IDLE; redirect coincident with a pop SHALL count the pop as accepted and the flush wins.
REQ-024 In DROP, the block SHALL hold imem_req_o=0, discard the next imem_ack_i, then go to IDLE; a further redirect in DROP SHALL only update fetch_pc.
REQ-025 Latency from imem_ack_i to valid_o SHALL be one cycle (without bypass).
REQ-026 imem_addr_o bits [1:0] SHALL always be 0; redirect_addr_i[1:0] SHALL be forced to 0.

Reset
REQ-027 While rst_i=0, the block SHALL hold state IDLE, count=0, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, inst_o=0, pc_o=0.
REQ-028 Reset asserted mid-request SHALL abandon it; a late imem_ack_i after reset release in IDLE SHALL be ignored.
REQ-029 The first request SHALL issue on the first clock edge after rst_i deasserts.

Configuration
REQ-030 With macro IFETCH_QUEUE_BYPASS_EN defined, when the queue is empty and imem_ack_i=1 in WAIT without redirect, valid_o/inst_o/pc_o SHALL present the response combinationally in the same cycle; if ready_i=1 it SHALL NOT be written to the queue.
REQ-031 Without IFETCH_QUEUE_BYPASS_EN, every response SHALL go through the queue with the one-cycle latency of REQ-025.

Verification
REQ-032 Reset release, memory ack 1 cycle after each request, ready_i=1 -> pc_o sequence 0x0,0x4,0x8,0xC; first valid_o 2 cycles after first request (no bypass).
REQ-033 ready_i=0 held, DEPTH=4 -> exactly 4 pushes, imem_req_o stays 0 afterwards; release ready_i -> pops in order 0x0..0xC.
REQ-034 Redirect to 0x40 while request to 0x8 outstanding, ack 3 cycles later -> that data discarded, next request addr 0x40, queue empty after redirect.
REQ-035 Redirect to 0x80 in the same cycle as imem_ack_i -> response dropped, next imem_addr_o=0x80, no DROP state entered.
REQ-036 fetch_pc=0xFFFFFFFC, ack -> pushed pc_o=0xFFFFFFFC, next imem_addr_o=0x00000000.
REQ-037 With IFETCH_QUEUE_BYPASS_EN, empty queue, ack of 0x20080005 at 0x10 -> valid_o=1, inst_o=0x20080005, pc_o=0x10 in the ack cycle.
